store_write_buffer: RTL and testbench

STORE_WRITE_BUFFER -- requirements
Module: store_write_buffer

---
 rtl/wbuf_pkg.sv | 17 +
 rtl/wbuf_fifo.sv | 59 +++++
 rtl/store_write_buffer.sv | 90 +++++++++
 tb/tb_store_write_buffer.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wbuf_pkg.sv
// Shared types for the store write buffer: entry layout and drain FSM states.
package wbuf_pkg;
   localparam int DEPTH_DEFAULT = 4;
   localparam int ADDR_W_MAX    = 64;

   // addr holds the doubleword index (byte address >> 3), zero-extended
   typedef struct packed {
      logic [ADDR_W_MAX-1:0] addr;
      logic [63:0]           data;
      logic [7:0]            strb;
   } wbuf_entry_t;

   typedef enum logic {
      IDLE  = 1'b0,
      ISSUE = 1'b1
   } wbuf_state_t;
endpackage

// File: rtl/wbuf_fifo.sv
// Circular entry storage with per-slot valid bits so every entry can be snooped in parallel.
module wbuf_fifo
   import wbuf_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEFAULT,
   localparam int PW   = $clog2(DEPTH),
   localparam int CW   = PW + 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_push,
   input  wbuf_entry_t i_push_entry,
   input  logic        i_pop,
   output wbuf_entry_t o_entries [DEPTH],
   output logic [DEPTH-1:0] o_valid,
   output logic [PW-1:0] o_rd_ptr,
   output logic [CW-1:0] o_count
);
   wbuf_entry_t      r_mem [DEPTH];
   logic [DEPTH-1:0] r_valid;
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;

   // Payload needs no reset: a slot is only observed while its valid bit is set
   always_ff @(posedge clk) begin
      if (i_push) begin
         r_mem[r_wr_ptr] <= i_push_entry;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid  <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) begin
            r_valid[r_wr_ptr] <= 1'b1;
            r_wr_ptr          <= r_wr_ptr + 1'b1;
         end
         if (i_pop) begin
            r_valid[r_rd_ptr] <= 1'b0;
            r_rd_ptr          <= r_rd_ptr + 1'b1;
         end
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_entries = r_mem;
   assign o_valid   = r_valid;
   assign o_rd_ptr  = r_rd_ptr;
   assign o_count   = r_count;
endmodule

// File: rtl/store_write_buffer.sv
// FIFO write buffer between cache and data memory: drain FSM plus load-hazard lookup.
module store_write_buffer
   import wbuf_pkg::*;
#(
   parameter int DEPTH  = DEPTH_DEFAULT,
   parameter int ADDR_W = 32,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = PW + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enq_valid,
   output logic              enq_ready,
   input  logic [ADDR_W-1:0] enq_addr,
   input  logic [63:0]       enq_data,
   input  logic [7:0]        enq_strb,
   output logic              mem_valid,
   input  logic              mem_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [63:0]       mem_wdata,
   output logic [7:0]        mem_wstrb,
   input  logic [ADDR_W-1:0] lk_addr,
   output logic              lk_hit,
   output logic              empty,
   output logic [CW-1:0]     count
);
   wbuf_state_t      r_state;
   wbuf_entry_t      w_entries [DEPTH];
   wbuf_entry_t      w_push_entry;
   logic [DEPTH-1:0] w_valid;
   logic [DEPTH-1:0] w_match;
   logic [PW-1:0]    w_rd_ptr;
   logic [CW-1:0]    w_count;
   logic [CW-1:0]    w_count_next;
   logic [ADDR_W_MAX-1:0] w_lk_dw;
   logic             w_push;
   logic             w_pop;
   logic             w_unused;

   // Byte offsets are irrelevant at doubleword granularity
   assign w_unused = &{1'b0, enq_addr[2:0], lk_addr[2:0]};

   assign enq_ready = ~rst & (w_count < CW'(DEPTH));
   assign mem_valid = ~rst & (r_state == ISSUE);
   assign w_push    = enq_valid & enq_ready;
   assign w_pop     = mem_valid & mem_ready;
   assign w_count_next = w_count - CW'(w_pop) + CW'(w_push);

   assign w_push_entry.addr = ADDR_W_MAX'(enq_addr[ADDR_W-1:3]);
   assign w_push_entry.data = enq_data;
   assign w_push_entry.strb = enq_strb;

   wbuf_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk          (clk),
      .rst          (rst),
      .i_push       (w_push),
      .i_push_entry (w_push_entry),
      .i_pop        (w_pop),
      .o_entries    (w_entries),
      .o_valid      (w_valid),
      .o_rd_ptr     (w_rd_ptr),
      .o_count      (w_count)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         case (r_state)
            IDLE:    if (w_count != '0) r_state <= ISSUE;
            ISSUE:   if (w_pop && (w_count_next == '0)) r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign mem_addr  = {w_entries[w_rd_ptr].addr[ADDR_W-4:0], 3'b000};
   assign mem_wdata = w_entries[w_rd_ptr].data;
   assign mem_wstrb = w_entries[w_rd_ptr].strb;

   // The popping head stays valid through its pop cycle, so it still hits
   assign w_lk_dw = ADDR_W_MAX'(lk_addr[ADDR_W-1:3]);
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
      assign w_match[gi] = w_valid[gi] & (w_entries[gi].addr == w_lk_dw);
   end
   assign lk_hit = ~rst & (|w_match);

   assign empty = rst | (w_count == '0);
   assign count = w_count;
endmodule

// File: tb/tb_store_write_buffer.sv
// Randomised self-checking bench for store_write_buffer against a queue-based model.
module tb_store_write_buffer;
   localparam int DEPTH  = 4;
   localparam int ADDR_W = 32;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              enq_valid = 1'b0;
   logic              enq_ready;
   logic [ADDR_W-1:0] enq_addr = '0;
   logic [63:0]       enq_data = '0;
   logic [7:0]        enq_strb = '0;
   logic              mem_valid;
   logic              mem_ready = 1'b0;
   logic [ADDR_W-1:0] mem_addr;
   logic [63:0]       mem_wdata;
   logic [7:0]        mem_wstrb;
   logic [ADDR_W-1:0] lk_addr = '0;
   logic              lk_hit;
   logic              empty;
   logic [2:0]        count;

   store_write_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .enq_valid (enq_valid),
      .enq_ready (enq_ready),
      .enq_addr  (enq_addr),
      .enq_data  (enq_data),
      .enq_strb  (enq_strb),
      .mem_valid (mem_valid),
      .mem_ready (mem_ready),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_wstrb (mem_wstrb),
      .lk_addr   (lk_addr),
      .lk_hit    (lk_hit),
      .empty     (empty),
      .count     (count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [63:0] data;
      logic [7:0]  strb;
   } wr_t;

   wr_t q[$];
   int  prev_size = 0;
   int  checks = 0;
   int  errors = 0;

   // mem_valid rises once the buffer has been non-empty across a clock edge
   function automatic bit exp_ready();
      return !rst && (q.size() < DEPTH);
   endfunction
   function automatic bit exp_mv();
      return !rst && (q.size() > 0) && (prev_size > 0);
   endfunction
   function automatic bit exp_hit();
      if (rst) return 1'b0;
      foreach (q[i]) if (q[i].addr[31:3] == lk_addr[31:3]) return 1'b1;
      return 1'b0;
   endfunction

   task automatic tick();
      bit push, pop;
      wr_t w;
      push = enq_valid && exp_ready();
      pop  = exp_mv() && mem_ready;
      w.addr = {enq_addr[31:3], 3'b000};
      w.data = enq_data;
      w.strb = enq_strb;
      @(posedge clk);
      if (rst) begin
         q.delete();
         prev_size = 0;
      end else begin
         prev_size = q.size();
         if (pop) q.delete(0);
         if (push) q.push_back(w);
      end
      #1;
   endtask

   task automatic set_push(input bit v, input logic [31:0] a);
      enq_valid = v;
      enq_addr  = a;
      enq_data  = {$urandom, $urandom};
      enq_strb  = 8'($urandom);
   endtask

   task automatic run_drain(input int bound);
      int n = 0;
      enq_valid = 1'b0;
      mem_ready = 1'b1;
      while (q.size() > 0 && n < bound) begin
         #1;
         checks++;
         if (mem_valid !== exp_mv()) begin
            errors++;
            $display("FAIL drain_valid got %0b want %0b", mem_valid, exp_mv());
         end
         if (exp_mv()) begin
            checks++;
            if (mem_addr !== q[0].addr || mem_wdata !== q[0].data || mem_wstrb !== q[0].strb) begin
               errors++;
               $display("FAIL drain_order got %h/%h/%h want %h/%h/%h", mem_addr, mem_wdata, mem_wstrb,
                        q[0].addr, q[0].data, q[0].strb);
            end else begin
               $display("mem write addr=%h data=%h strb=%h", mem_addr, mem_wdata, mem_wstrb);
            end
         end
         tick();
         n++;
      end
      checks++;
      if (q.size() != 0 || empty !== 1'b1) begin
         errors++;
         $display("FAIL drain_timeout got empty=%0b want 1", empty);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      #1;
      checks++;
      if ({mem_valid, empty, lk_hit, enq_ready} !== 4'b0100) begin
         errors++;
         $display("FAIL reset_outputs got %b want 0100", {mem_valid, empty, lk_hit, enq_ready});
      end
      tick();
      rst = 1'b0;
      #1;
      checks++;
      if (count !== 3'd0 || empty !== 1'b1 || enq_ready !== 1'b1 || mem_valid !== 1'b0) begin
         errors++;
         $display("FAIL post_reset got count=%0d empty=%0b ready=%0b", count, empty, enq_ready);
      end
   endtask

   task automatic test_single();
      mem_ready = 1'b1;
      set_push(1'b1, 32'h9004);
      enq_data = 64'h1122334455667788;
      enq_strb = 8'hFF;
      tick();
      enq_valid = 1'b0;
      #1;
      checks++;
      if (mem_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_latency got %0b want 0", mem_valid);
      end
      tick();
      checks++;
      if (mem_valid !== 1'b1 || mem_addr !== 32'h9000 || mem_wdata !== 64'h1122334455667788) begin
         errors++;
         $display("FAIL single_issue got %0b %h %h want 1 9000 1122334455667788", mem_valid, mem_addr, mem_wdata);
      end
      tick();
      checks++;
      if (empty !== 1'b1 || mem_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_empty got %0b want 1", empty);
      end
   endtask

   task automatic test_fill();
      mem_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         set_push(1'b1, 32'h8000 + 32'(i * 8));
         #1;
         checks++;
         if (enq_ready !== exp_ready() || enq_ready !== (i < 4)) begin
            errors++;
            $display("FAIL fill_ready[%0d] got %0b want %0b", i, enq_ready, exp_ready());
         end
         tick();
      end
      enq_valid = 1'b0;
      checks++;
      if (count !== 3'd4) begin
         errors++;
         $display("FAIL fill_count got %0d want 4", count);
      end
      run_drain(8);
   endtask

   task automatic test_full_pushpop();
      mem_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         set_push(1'b1, 32'hA000 + 32'(i * 8));
         tick();
      end
      set_push(1'b1, 32'hB000);
      mem_ready = 1'b1;
      #1;
      checks++;
      if (enq_ready !== 1'b0 || mem_valid !== 1'b1) begin
         errors++;
         $display("FAIL full_refuse got ready=%0b valid=%0b want 0 1", enq_ready, mem_valid);
      end
      tick();
      mem_ready = 1'b0;
      checks++;
      if (count !== 3'd3 || enq_ready !== 1'b1) begin
         errors++;
         $display("FAIL full_after_pop got count=%0d want 3", count);
      end
      tick();
      enq_valid = 1'b0;
      checks++;
      if (count !== 3'd4 || q[3].addr !== 32'hB000) begin
         errors++;
         $display("FAIL full_accept got count=%0d want 4", count);
      end
      run_drain(8);
   endtask

   task automatic test_hazard();
      mem_ready = 1'b0;
      set_push(1'b1, 32'h9078);
      lk_addr = 32'h907C;
      #1;
      checks++;
      if (lk_hit !== 1'b0) begin
         errors++;
         $display("FAIL hazard_same_cycle got %0b want 0", lk_hit);
      end
      tick();
      enq_valid = 1'b0;
      #1;
      checks++;
      if (lk_hit !== exp_hit() || lk_hit !== 1'b1) begin
         errors++;
         $display("FAIL hazard_hit got %0b want 1", lk_hit);
      end
      lk_addr = 32'h9080;
      #1;
      checks++;
      if (lk_hit !== 1'b0) begin
         errors++;
         $display("FAIL hazard_miss got %0b want 0", lk_hit);
      end
      lk_addr = 32'h907C;
      tick();
      mem_ready = 1'b1;
      #1;
      checks++;
      if (lk_hit !== 1'b1 || mem_valid !== 1'b1) begin
         errors++;
         $display("FAIL hazard_pop_cycle got hit=%0b valid=%0b want 1 1", lk_hit, mem_valid);
      end
      tick();
      checks++;
      if (lk_hit !== 1'b0) begin
         errors++;
         $display("FAIL hazard_clear got %0b want 0", lk_hit);
      end
      mem_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         set_push(1'b1, 32'hC000 + 32'(i * 8));
         tick();
      end
      enq_valid = 1'b0;
      checks++;
      if (mem_valid !== 1'b1 || count !== 3'd3) begin
         errors++;
         $display("FAIL rstmid_setup got valid=%0b count=%0d want 1 3", mem_valid, count);
      end
      rst = 1'b1;
      mem_ready = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (mem_valid !== 1'b0 || count !== 3'd0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_after[%0d] got valid=%0b count=%0d empty=%0b", i, mem_valid, count, empty);
         end
         tick();
      end
      mem_ready = 1'b0;
   endtask

   task automatic test_wrap();
      int pushes = 0;
      int pops = 0;
      mem_ready = 1'b1;
      for (int c = 0; c < 20; c++) begin
         set_push(pushes < 10, 32'hD000 + 32'(pushes * 8));
         #1;
         if (exp_mv()) begin
            checks++;
            if (mem_valid !== 1'b1 || mem_addr !== q[0].addr || mem_wdata !== q[0].data) begin
               errors++;
               $display("FAIL wrap_order got %0b %h want 1 %h", mem_valid, mem_addr, q[0].addr);
            end else begin
               $display("mem write addr=%h data=%h strb=%h", mem_addr, mem_wdata, mem_wstrb);
            end
            pops++;
         end
         checks++;
         if (int'(count) > 2 || int'(count) != q.size()) begin
            errors++;
            $display("FAIL wrap_count got %0d want %0d", count, q.size());
         end
         if (enq_valid && exp_ready()) pushes++;
         tick();
      end
      enq_valid = 1'b0;
      checks++;
      if (pops != 10) begin
         errors++;
         $display("FAIL wrap_total got %0d want 10", pops);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         rst = ($urandom_range(0, 99) == 0);
         set_push($urandom_range(0, 1) == 1, 32'h9000 + 32'($urandom_range(0, 63)));
         mem_ready = ($urandom_range(0, 2) != 0);
         lk_addr = 32'h9000 + 32'($urandom_range(0, 63));
         #1;
         checks++;
         if (enq_ready !== exp_ready() || mem_valid !== exp_mv() || lk_hit !== exp_hit()) begin
            errors++;
            $display("FAIL rand_ctrl[%0d] got %b want %b", c, {enq_ready, mem_valid, lk_hit},
                     {exp_ready(), exp_mv(), exp_hit()});
         end
         if (!rst) begin
            checks++;
            if (int'(count) != q.size() || empty !== (q.size() == 0)) begin
               errors++;
               $display("FAIL rand_count[%0d] got %0d want %0d", c, count, q.size());
            end
         end
         if (exp_mv()) begin
            checks++;
            if (mem_addr !== q[0].addr || mem_wdata !== q[0].data || mem_wstrb !== q[0].strb) begin
               errors++;
               $display("FAIL rand_head[%0d] got %h want %h", c, mem_addr, q[0].addr);
            end
         end
         tick();
      end
      rst = 1'b0;
      run_drain(8);
   endtask

   initial begin
      @(posedge clk);
      #1;
      test_reset();
      test_single();
      test_fill();
      test_full_pushpop();
      test_hazard();
      test_reset_mid();
      test_wrap();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog");
   end
endmodule
